// File: rtl/oled_spi_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | oled_spi_receiver: PmodOLEDrgb SPI sniffer, rebuilds bytes/RGB565 pixels  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module oled_spi_receiver #(
  parameter int WIDTH  = 96,
  parameter int HEIGHT = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        sclk,
  input  logic        sdin,
  input  logic        d_cn,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [6:0]  pix_x,
  output logic [5:0]  pix_y,
  output logic        frame_done,
  output logic        abort_err
);

  localparam logic [6:0] X_LAST = 7'(WIDTH - 1);
  localparam logic [5:0] Y_LAST = 6'(HEIGHT - 1);

  typedef enum logic [0:0] {B_IDLE = 1'b0, B_SHIFT = 1'b1} byte_state_t;
  typedef enum logic [0:0] {P_HI = 1'b0, P_LO = 1'b1} pix_state_t;

  // cs and sclk synchronisers reset to their idle-high level so that
  // releasing reset with sclk high does not fabricate a rising edge.
  logic [1:0] cs_s;
  logic [2:0] sclk_s;
  logic [1:0] sdin_s;
  logic [1:0] dc_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_s   <= 2'b11;
      sclk_s <= 3'b111;
      sdin_s <= 2'b00;
      dc_s   <= 2'b00;
    end else begin
      cs_s   <= {cs_s[0], cs};
      sclk_s <= {sclk_s[1:0], sclk};
      sdin_s <= {sdin_s[0], sdin};
      dc_s   <= {dc_s[0], d_cn};
    end
  end

  logic       sclk_rise;
  logic [7:0] shifted;
  logic [2:0] cnt_next;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic       byte_abort;
  byte_state_t bstate;

  assign sclk_rise = sclk_s[1] & ~sclk_s[2];
  assign shifted   = {shreg, sdin_s[1]};
  assign cnt_next  = sclk_rise ? bit_cnt + 3'd1 : bit_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bstate     <= B_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
      byte_abort <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_abort <= 1'b0;
      case (bstate)
        B_IDLE: begin
          bit_cnt <= '0;
          if (!cs_s[1]) bstate <= B_SHIFT;
        end
        B_SHIFT: begin
          if (sclk_rise) begin
            shreg <= shifted[6:0];
            if (bit_cnt == 3'd7) begin
              byte_data  <= shifted;
              byte_dc    <= dc_s[1];
              byte_valid <= 1'b1;
            end
          end
          // The counter wraps 7 -> 0 naturally on the completing rise.
          bit_cnt <= cnt_next;
          if (cs_s[1]) begin
            bstate     <= B_IDLE;
            bit_cnt    <= '0;
            byte_abort <= (cnt_next != 3'd0);
          end
        end
        default: bstate <= B_IDLE;
      endcase
    end
  end

  logic [7:0] hi_byte;
  logic [6:0] cur_x;
  logic [5:0] cur_y;
  logic       pix_abort;
  pix_state_t pstate;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pstate     <= P_HI;
      hi_byte    <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      frame_done <= 1'b0;
      pix_abort  <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      pix_abort  <= 1'b0;
      if (byte_valid) begin
        if (!byte_dc) begin
          cur_x     <= '0;
          cur_y     <= '0;
          pix_abort <= (pstate == P_LO);
          pstate    <= P_HI;
        end else if (pstate == P_HI) begin
          hi_byte <= byte_data;
          pstate  <= P_LO;
        end else begin
          pix_data   <= {hi_byte, byte_data};
          pix_valid  <= 1'b1;
          pix_x      <= cur_x;
          pix_y      <= cur_y;
          frame_done <= (cur_x == X_LAST) && (cur_y == Y_LAST);
          pstate     <= P_HI;
          if (cur_x == X_LAST) begin
            cur_x <= '0;
            cur_y <= (cur_y == Y_LAST) ? 6'd0 : cur_y + 6'd1;
          end else begin
            cur_x <= cur_x + 7'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                      abort_err <= 1'b0;
    else if (byte_abort || pix_abort)  abort_err <= 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_oled_spi_receiver: randomized bench with a pixel-index reference model |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_oled_spi_receiver;

  localparam int W    = 96;
  localparam int H    = 3;   // short panel keeps a full frame cheap to simulate
  localparam int HALF = 4;   // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        reset_n, cs, sclk, sdin, d_cn;
  logic        byte_valid, byte_dc, pix_valid, frame_done, abort_err;
  logic [7:0]  byte_data;
  logic [15:0] pix_data;
  logic [6:0]  pix_x;
  logic [5:0]  pix_y;

  oled_spi_receiver #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .sclk(sclk), .sdin(sdin), .d_cn(d_cn),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_done(frame_done), .abort_err(abort_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic dc; } byte_rec_t;
  typedef struct packed { logic [15:0] d; logic [6:0] x; logic [5:0] y; logic fd; logic [7:0] lat; } pix_rec_t;

  byte_rec_t obs_b[$], exp_b[$];
  pix_rec_t  obs_p[$], exp_p[$];
  int        obs_bcyc[$];
  int        cyc = 0, last_byte_cyc = 0, stray_frame = 0;
  int        tests = 0, fails = 0;

  int         m_idx;
  bit         m_pend, m_abort;
  logic [7:0] m_hi;

  always @(negedge clk) begin
    cyc++;
    if (pix_valid) obs_p.push_back('{pix_data, pix_x, pix_y, frame_done, 8'(cyc - last_byte_cyc)});
    if (frame_done && !pix_valid) stray_frame++;
    if (byte_valid) begin
      obs_b.push_back('{byte_data, byte_dc});
      obs_bcyc.push_back(cyc);
      last_byte_cyc = cyc;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, fails so far %0d", fails);
    $fatal(1, "watchdog");
  end

  // Reference model: pixels are numbered from the last command byte.
  task automatic model_byte(input logic [7:0] b, input logic dc);
    pix_rec_t p;
    exp_b.push_back('{b, dc});
    if (!dc) begin
      if (m_pend) m_abort = 1'b1;
      m_pend = 1'b0;
      m_idx  = 0;
    end else if (!m_pend) begin
      m_hi   = b;
      m_pend = 1'b1;
    end else begin
      p.d   = {m_hi, b};
      p.x   = 7'(m_idx % W);
      p.y   = 6'((m_idx / W) % H);
      p.fd  = ((m_idx % (W * H)) == W * H - 1);
      p.lat = 8'd1;
      exp_p.push_back(p);
      m_idx++;
      m_pend = 1'b0;
    end
  endtask

  task automatic clear_q();
    obs_b.delete(); exp_b.delete(); obs_p.delete(); exp_p.delete(); obs_bcyc.delete();
    stray_frame = 0;
  endtask

  task automatic model_reset();
    m_idx = 0; m_pend = 1'b0; m_abort = 1'b0; m_hi = '0;
    clear_q();
  endtask

  task automatic spi_bits(input logic [7:0] b, input logic dc, input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0; sdin = b[7-i]; d_cn = dc;
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic dc);
    spi_bits(b, dc, 8);
    model_byte(b, dc);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; cs = 1'b1; sclk = 1'b1; sdin = 1'b0; d_cn = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({byte_valid, byte_data, byte_dc, pix_valid, pix_data, pix_x, pix_y, frame_done, abort_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got bv=%b bd=%h dc=%b pv=%b pd=%h x=%0d y=%0d fd=%b ab=%b, required all 0",
               byte_valid, byte_data, byte_dc, pix_valid, pix_data, pix_x, pix_y, frame_done, abort_err);
    end
  endtask

  task automatic test_command();
    cs_low();
    send(8'hAF, 1'b0);
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    cs_high();
    tests++;
    if (obs_b.size() != exp_b.size()) begin
      fails++; $display("FAIL cmd_count: got %0d required %0d", obs_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      tests++;
      if (obs_b[i] !== exp_b[i]) begin
        fails++; $display("FAIL cmd_byte[%0d]: got %h/%b required %h/%b", i, obs_b[i].d, obs_b[i].dc, exp_b[i].d, exp_b[i].dc);
      end
    end
    tests++;
    if (obs_p.size() != 0 || abort_err !== 1'b0) begin
      fails++; $display("FAIL cmd_side: got %0d pixels abort=%b required 0 pixels abort=0", obs_p.size(), abort_err);
    end
    clear_q();
  endtask

  task automatic test_pixel();
    cs_low();
    send(8'h15, 1'b0);
    send(8'hF8, 1'b1); send(8'h00, 1'b1);
    send(8'h07, 1'b1); send(8'hE0, 1'b1);
    for (int i = 0; i < 6; i++) send(8'($urandom), 1'b1);
    cs_high();
    tests++;
    if (obs_p.size() != exp_p.size()) begin
      fails++; $display("FAIL pix_count: got %0d required %0d", obs_p.size(), exp_p.size());
    end
    for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
      tests++;
      if (obs_p[i] !== exp_p[i]) begin
        fails++; $display("FAIL pixel[%0d]: got %h (%0d,%0d) fd=%b lat=%0d required %h (%0d,%0d) fd=%b lat=%0d", i,
                          obs_p[i].d, obs_p[i].x, obs_p[i].y, obs_p[i].fd, obs_p[i].lat,
                          exp_p[i].d, exp_p[i].x, exp_p[i].y, exp_p[i].fd, exp_p[i].lat);
      end
    end
    tests++;
    if (abort_err !== m_abort) begin
      fails++; $display("FAIL pix_abort: got %b required %b", abort_err, m_abort);
    end
    clear_q();
  endtask

  task automatic test_orphan();
    tests++;
    if (abort_err !== 1'b0) begin
      fails++; $display("FAIL orphan_pre_abort: got %b required 0", abort_err);
    end
    cs_low();
    send(8'h12, 1'b1);
    send(8'hA0, 1'b0);
    send(8'($urandom), 1'b1); send(8'($urandom), 1'b1);
    cs_high();
    tests++;
    if (obs_p.size() != 1 || exp_p.size() != 1) begin
      fails++; $display("FAIL orphan_count: got %0d required %0d", obs_p.size(), exp_p.size());
    end else begin
      tests++;
      if (obs_p[0] !== exp_p[0]) begin
        fails++; $display("FAIL orphan_pixel: got %h (%0d,%0d) required %h (%0d,%0d)",
                          obs_p[0].d, obs_p[0].x, obs_p[0].y, exp_p[0].d, exp_p[0].x, exp_p[0].y);
      end
    end
    tests++;
    if (abort_err !== m_abort) begin
      fails++; $display("FAIL orphan_abort: got %b required %b", abort_err, m_abort);
    end
    clear_q();
  endtask

  task automatic test_abort_byte();
    cs_low();
    spi_bits(8'($urandom), 1'b1, 5);
    cs_high();
    m_abort = 1'b1;
    tests++;
    if (obs_b.size() != 0 || abort_err !== m_abort) begin
      fails++; $display("FAIL abort_partial: got %0d bytes abort=%b required 0 bytes abort=1", obs_b.size(), abort_err);
    end
    cs_low();
    send(8'h3C, 1'b0);
    cs_high();
    tests++;
    if (obs_b.size() != 1 || obs_b[0] !== exp_b[0]) begin
      fails++; $display("FAIL abort_next_byte: got %0d bytes first=%h required 1 byte %h",
                        obs_b.size(), (obs_b.size() > 0) ? obs_b[0].d : 8'h00, exp_b[0].d);
    end
    clear_q();
  endtask

  task automatic test_reset_mid();
    cs_low();
    send(8'h81, 1'b1);
    spi_bits(8'hFF, 1'b1, 4);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({byte_valid, byte_data, byte_dc, pix_valid, pix_data, pix_x, pix_y, frame_done, abort_err} !== '0) begin
      fails++; $display("FAIL midreset_outputs: got bd=%h dc=%b pd=%h ab=%b required all 0",
                        byte_data, byte_dc, pix_data, abort_err);
    end
    reset_n = 1'b1;
    model_reset();
    cs_high();
    cs_low();
    send(8'h55, 1'b1);
    send(8'h66, 1'b1);
    cs_high();
    tests++;
    if (obs_b.size() != 2 || obs_b[0] !== exp_b[0]) begin
      fails++; $display("FAIL midreset_byte: got %0d bytes first=%h required 2 bytes first=%h",
                        obs_b.size(), (obs_b.size() > 0) ? obs_b[0].d : 8'h00, exp_b[0].d);
    end
    tests++;
    if (obs_p.size() != 1 || obs_p[0] !== exp_p[0]) begin
      fails++; $display("FAIL midreset_pixel: got %0d pixels first=%h required 1 pixel %h at (0,0)",
                        obs_p.size(), (obs_p.size() > 0) ? obs_p[0].d : 16'h0, exp_p[0].d);
    end
    clear_q();
  endtask

  task automatic test_frame();
    int bad_pix, bad_gap, fd_obs, fd_exp;
    bad_pix = 0; bad_gap = 0; fd_obs = 0; fd_exp = 0;
    cs_low();
    send(8'h5C, 1'b0);
    for (int i = 0; i < 2 * W * H + 4; i++) send(8'($urandom), 1'b1);
    cs_high();
    tests++;
    if (obs_p.size() != exp_p.size()) begin
      fails++; $display("FAIL frame_count: got %0d required %0d", obs_p.size(), exp_p.size());
    end
    for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
      if (obs_p[i].fd) fd_obs++;
      if (exp_p[i].fd) fd_exp++;
      if (obs_p[i] !== exp_p[i]) begin
        bad_pix++;
        if (bad_pix <= 4)
          $display("FAIL frame_pixel[%0d]: got %h (%0d,%0d) fd=%b required %h (%0d,%0d) fd=%b", i,
                   obs_p[i].d, obs_p[i].x, obs_p[i].y, obs_p[i].fd, exp_p[i].d, exp_p[i].x, exp_p[i].y, exp_p[i].fd);
      end
    end
    tests++;
    if (bad_pix != 0) begin
      fails++; $display("FAIL frame_pixels: got %0d wrong pixels required 0", bad_pix);
    end
    tests++;
    if (fd_obs != fd_exp || stray_frame != 0) begin
      fails++; $display("FAIL frame_done: got %0d (+%0d stray) required %0d", fd_obs, stray_frame, fd_exp);
    end
    for (int i = 1; i < obs_bcyc.size(); i++)
      if (obs_bcyc[i] - obs_bcyc[i-1] != 16 * HALF) bad_gap++;
    tests++;
    if (bad_gap != 0 || obs_b.size() != exp_b.size()) begin
      fails++; $display("FAIL back_to_back: got %0d bad gaps, %0d bytes required 0 gaps, %0d bytes",
                        bad_gap, obs_b.size(), exp_b.size());
    end
    clear_q();
  endtask

  initial begin
    reset_n = 1'b0; cs = 1'b1; sclk = 1'b1; sdin = 1'b0; d_cn = 1'b0;
    test_reset();
    test_command();
    test_pixel();
    test_orphan();
    apply_reset();
    test_abort_byte();
    test_reset_mid();
    apply_reset();
    test_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oled_spi_receiver.md
# oled_spi_receiver

Receive-side model of the PmodOLEDrgb serial link: samples the `cs`/`sdin`/`sclk`/`d_cn` lines that the OLED driver puts on `JB`, rebuilds bytes, separates command bytes from pixel data, and reassembles RGB565 pixels with their (x, y) coordinate on the 96x64 panel. It runs on the 100 MHz system clock, treats the SPI lines as asynchronous, and sits in loopback and self-check builds, where a second Pmod header or an internal tap of `JB` feeds it.

## Interface
Parameters:
- `WIDTH`, 96: panel columns; `pix_x` wraps at `WIDTH-1`.
- `HEIGHT`, 64: panel rows; `pix_y` wraps at `HEIGHT-1`.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cs`  in  1  SPI chip select, active low, asynchronous to `clk`.
- `sclk`  in  1  SPI clock, idle high, asynchronous.
- `sdin`  in  1  SPI data, MSB first, asynchronous.
- `d_cn`  in  1  data/command select, 1 = data, asynchronous.
- `byte_valid`  out  1  one-cycle pulse when a byte completes.
- `byte_data`  out  8  completed byte, held until the next completed byte.
- `byte_dc`  out  1  `d_cn` sampled with the byte's last bit.
- `pix_valid`  out  1  one-cycle pulse when a pixel completes.
- `pix_data`  out  16  RGB565 pixel, held until the next pixel.
- `pix_x`  out  7  column of `pix_data`.
- `pix_y`  out  6  row of `pix_data`.
- `frame_done`  out  1  one-cycle pulse, coincident with `pix_valid` of pixel (`WIDTH-1`, `HEIGHT-1`).
- `abort_err`  out  1  sticky flag; cleared only by reset.

## Operation
- **Synchronisation.** Each of `cs`, `sclk`, `sdin` and `d_cn` passes through its own 2-flop synchroniser, so all four lines keep equal latency. A third register on `sclk` gives `sclk_rise = s2 & ~s3`.
- **Byte state machine** (states IDLE, SHIFT):
  - IDLE: the bit counter is 0. On synchronised `cs` = 0, go to SHIFT.
  - SHIFT: on each `sclk_rise`, shift `sdin` into the LSB of the shift register and increment the 3-bit counter.
  - On the rise that completes bit 7 (counter = 7), register `byte_data` and `byte_dc` (current `d_cn`), pulse `byte_valid`, clear the counter to 0 and stay in SHIFT.
  - Synchronised `cs` = 1 returns the machine to IDLE. If the counter is nonzero at that point, the partial byte is discarded, `abort_err` is set and no `byte_valid` is issued.
- **Pixel assembler** (states HI, LO), acting on each `byte_valid`:
  - `byte_dc` = 1, state HI: store the byte as the high byte and go to LO.
  - `byte_dc` = 1, state LO: `pix_data` = {high, byte}, pulse `pix_valid`, output the current `pix_x`/`pix_y`, advance the coordinate, go to HI.
  - Coordinate advance: `pix_x` increments and wraps to 0 at `WIDTH-1`; on that wrap `pix_y` increments and wraps to 0 at `HEIGHT-1`. The (`WIDTH-1`, `HEIGHT-1`) pixel also pulses `frame_done`.
  - `byte_dc` = 0 (any command byte): coordinate resets to (0, 0) and state goes to HI. A pending high byte is dropped and sets `abort_err`.
- **Width rules.** `pix_x` and `pix_y` are compared against `WIDTH-1`/`HEIGHT-1`, never against the register width. `pix_x`/`pix_y` on the output are the values before the advance.

## Timing
- Reset values: every output is 0, byte FSM is IDLE, pixel FSM is HI, coordinate is (0, 0), shift register and counter are 0.
- Latency: let clk edge k be the first to sample raw `sclk` high on bit 7. `byte_valid` is high during cycle k+2→k+3. `pix_valid` and `frame_done` are high exactly one cycle later than `byte_valid`.
- Input constraints:
  - `sclk` high and low phases are each at least 3 `clk` periods.
  - `sdin` and `d_cn` are stable for at least 3 `clk` periods around the `sclk` rising edge.
  - `cs` setup before the first `sclk` fall is at least 3 `clk` periods.
- Simultaneous `sclk_rise` and `cs` deassertion: the rise is processed first (it may complete a byte), then the machine returns to IDLE. An abort is flagged only if the counter is still nonzero after that rise.
- Asserting `reset_n` mid-byte or mid-pixel clears all state immediately. The first byte after release starts at bit 0.
- Back-to-back bytes with `cs` held low give a `byte_valid` every 8 `sclk` rises, with no gap cycles.

## Test plan
- **Single command byte.** `cs` = 0, `d_cn` = 0, shift 0xAF at 3.125 MHz → one `byte_valid`, `byte_data` = 0xAF, `byte_dc` = 0, no `pix_valid`, `abort_err` = 0.
- **Pixel assembly.** Command 0x15, then data 0xF8, 0x00 → `pix_valid` once, `pix_data` = 0xF800 at (0, 0). The next data pair 0x07, 0xE0 → 0x07E0 at (1, 0).
- **Full frame.** Command byte, then 12288 data bytes → 6144 `pix_valid` pulses; the row wraps after x = 95. The last pixel is at (95, 63) with `frame_done` asserted in the same cycle. The next pixel is at (0, 0).
- **Aborted byte.** Shift 5 bits, deassert `cs` → no `byte_valid`, `abort_err` = 1. The following complete byte 0x3C is received correctly.
- **Orphan high byte.** Data 0x12, then command 0xA0 → no `pix_valid`, `abort_err` = 1. The next data pair is reported at (0, 0).
- **Reset mid-byte.** Pulse `reset_n` low after bit 4 → all outputs 0. A subsequent byte 0x55 is decoded as 0x55.
